// File: rtl/sram_arbiter_pkg.sv
// Shared types for the external SRAM sequencer/arbiter.
// Exports arb_state_t, arb_owner_t, SRAM_AW and a one-hot to owner helper.
package sram_arbiter_pkg;

  localparam int SRAM_AW = 19;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ACC1 = 2'd1,
    ARB_ACC2 = 2'd2
  } arb_state_t;

  // Values double as bit positions in the picker's one-hot winner.
  typedef enum logic [1:0] {
    OWN_VID = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } arb_owner_t;

  function automatic arb_owner_t oh2owner(input logic [2:0] oh);
    arb_owner_t o;
    o = OWN_VID;
    if (oh[1]) o = OWN_CPU;
    if (oh[2]) o = OWN_DMA;
    return o;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational priority picker: video > promoted DMA > CPU > DMA.
// Ports: vid/cpu/dma_req_i, promote_i in; one-hot win_o, any_o out.
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic       vid_req_i,
  input  logic       cpu_req_i,
  input  logic       dma_req_i,
  input  logic       promote_i,
  output logic [2:0] win_o,
  output logic       any_o
);

  always_comb begin
    win_o = '0;
    priority case (1'b1)
      vid_req_i:              win_o[OWN_VID] = 1'b1;
      dma_req_i && promote_i: win_o[OWN_DMA] = 1'b1;
      cpu_req_i:              win_o[OWN_CPU] = 1'b1;
      dma_req_i:              win_o[OWN_DMA] = 1'b1;
      default:                win_o = '0;
    endcase
  end

  assign any_o = vid_req_i | cpu_req_i | dma_req_i;

endmodule

// File: rtl/sram_arbiter.sv
// Two-cycle SRAM sequencer arbitrating video, CPU and DMA requesters.
// Ports: clk28/rst_n, vid_*, cpu_*, dma_* requesters, va/vd_*/n_vrd/n_vwr SRAM pins.
// Define SRAM_ARBITER_DMA_EN to enable the DMA port and starvation counter.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic               clk28,
  input  logic               rst_n,
  input  logic               vid_req,
  input  logic [SRAM_AW-1:0] vid_addr,
  output logic               vid_ack,
  output logic [7:0]         vid_rdata,
  output logic               vid_rvalid,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [SRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_rvalid,
  input  logic               dma_req,
  input  logic               dma_wr,
  input  logic [SRAM_AW-1:0] dma_addr,
  input  logic [7:0]         dma_wdata,
  output logic               dma_ack,
  output logic [7:0]         dma_rdata,
  output logic               dma_rvalid,
  output logic [SRAM_AW-1:0] va,
  output logic [7:0]         vd_out,
  output logic               vd_oe,
  input  logic [7:0]         vd_in,
  output logic               n_vrd,
  output logic               n_vwr
);

  arb_state_t         state_q, state_d;
  arb_owner_t         owner_q, owner_d;
  logic               wr_q, wr_d;
  logic [SRAM_AW-1:0] va_q, va_d;
  logic [7:0]         vd_out_q, vd_out_d;
  logic               vd_oe_q, vd_oe_d;
  logic               n_vrd_q, n_vrd_d;
  logic               n_vwr_q, n_vwr_d;
  logic [2:0][7:0]    rdata_q;
  logic [2:0]         rvalid_q, rvalid_d;

  logic               dma_req_eff;
  logic               promote;
  logic [2:0]         win;
  logic               any;
  logic               arb_pt;

  assign arb_pt = (state_q == ARB_IDLE) || (state_q == ARB_ACC2);

  sram_arb_pick u_pick (
    .vid_req_i (vid_req),
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_req_eff),
    .promote_i (promote),
    .win_o     (win),
    .any_o     (any)
  );

`ifdef SRAM_ARBITER_DMA_EN
  logic [3:0] cnt_q, cnt_d;

  assign dma_req_eff = dma_req;
  assign promote     = (cnt_q == 4'(DMA_MAX_WAIT));

  // Counts CPU wins while DMA waits; never passes the threshold
  // because a promoted DMA always beats the CPU.
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req) begin
      cnt_d = '0;
    end else if (arb_pt && any) begin
      if (win[OWN_DMA])      cnt_d = '0;
      else if (win[OWN_CPU]) cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_dma_req;
  assign unused_dma_req = dma_req;
  assign dma_req_eff    = 1'b0;
  assign promote        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    va_d     = va_q;
    vd_out_d = vd_out_q;
    vd_oe_d  = vd_oe_q;
    n_vrd_d  = n_vrd_q;
    n_vwr_d  = n_vwr_q;
    rvalid_d = '0;

    if (state_q == ARB_ACC1) begin
      state_d = ARB_ACC2;
      // Address/data were set up during ACC1; strobe write now.
      n_vwr_d = ~wr_q;
    end

    if (state_q == ARB_ACC2 && !wr_q) begin
      rvalid_d[owner_q] = 1'b1;
    end

    if (arb_pt) begin
      if (any) begin
        state_d = ARB_ACC1;
        owner_d = oh2owner(win);
        unique case (1'b1)
          win[OWN_VID]: begin
            wr_d     = 1'b0;
            va_d     = vid_addr;
            vd_out_d = '0;
          end
          win[OWN_CPU]: begin
            wr_d     = cpu_wr;
            va_d     = cpu_addr;
            vd_out_d = cpu_wdata;
          end
          win[OWN_DMA]: begin
            wr_d     = dma_wr;
            va_d     = dma_addr;
            vd_out_d = dma_wdata;
          end
          default: begin
            wr_d = 1'b0;
          end
        endcase
        vd_oe_d = wr_d;
        n_vrd_d = wr_d;
        n_vwr_d = 1'b1;
      end else begin
        state_d = ARB_IDLE;
        vd_oe_d = 1'b0;
        n_vrd_d = 1'b1;
        n_vwr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_VID;
      wr_q     <= 1'b0;
      va_q     <= '0;
      vd_out_q <= '0;
      vd_oe_q  <= 1'b0;
      n_vrd_q  <= 1'b1;
      n_vwr_q  <= 1'b1;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      va_q     <= va_d;
      vd_out_q <= vd_out_d;
      vd_oe_q  <= vd_oe_d;
      n_vrd_q  <= n_vrd_d;
      n_vwr_q  <= n_vwr_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state_q == ARB_ACC2 && !wr_q) begin
      rdata_q[owner_q] <= vd_in;
    end
  end

  assign va     = va_q;
  assign vd_out = vd_out_q;
  assign vd_oe  = vd_oe_q;
  assign n_vrd  = n_vrd_q;
  assign n_vwr  = n_vwr_q;

  assign vid_ack    = (state_q == ARB_ACC1) && (owner_q == OWN_VID);
  assign cpu_ack    = (state_q == ARB_ACC1) && (owner_q == OWN_CPU);
  assign vid_rdata  = rdata_q[OWN_VID];
  assign cpu_rdata  = rdata_q[OWN_CPU];
  assign vid_rvalid = rvalid_q[OWN_VID];
  assign cpu_rvalid = rvalid_q[OWN_CPU];

`ifdef SRAM_ARBITER_DMA_EN
  assign dma_ack    = (state_q == ARB_ACC1) && (owner_q == OWN_DMA);
  assign dma_rdata  = rdata_q[OWN_DMA];
  assign dma_rvalid = rvalid_q[OWN_DMA];
`else
  assign dma_ack    = 1'b0;
  assign dma_rdata  = '0;
  assign dma_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
// Covers reset, read/write timing, priority, reset abort and DMA handling.
module tb_sram_arbiter;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        vid_req;
  logic [18:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic        vid_rvalid;
  logic        cpu_req;
  logic        cpu_wr;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        dma_req;
  logic        dma_wr;
  logic [18:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [18:0] va;
  logic [7:0]  vd_out;
  logic        vd_oe;
  logic [7:0]  vd_in;
  logic        n_vrd;
  logic        n_vwr;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk28 = ~clk28;

  sram_arbiter #(.DMA_MAX_WAIT(8)) dut (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_rdata  (vid_rdata),
    .vid_rvalid (vid_rvalid),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .va         (va),
    .vd_out     (vd_out),
    .vd_oe      (vd_oe),
    .vd_in      (vd_in),
    .n_vrd      (n_vrd),
    .n_vwr      (n_vwr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    vid_req   = 1'b1;
    vid_addr  = 19'h40000;
    cpu_req   = 1'b1;
    cpu_wr    = 1'b0;
    cpu_addr  = 19'h00100;
    cpu_wdata = 8'h00;
    dma_req   = 1'b1;
    dma_wr    = 1'b0;
    dma_addr  = 19'h00200;
    dma_wdata = 8'h00;
    vd_in     = 8'h00;

    // Reset with every request pending.
    repeat (3) @(negedge clk28);
    chk("rst_n_vrd", 32'(n_vrd), 32'd1);
    chk("rst_n_vwr", 32'(n_vwr), 32'd1);
    chk("rst_vid_ack", 32'(vid_ack), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_va", 32'(va), 32'd0);
    chk("rst_vd_oe", 32'(vd_oe), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    rst_n = 1'b1;

    // Video wins first, then the held CPU request.
    @(negedge clk28);
    chk("first_vid_ack", 32'(vid_ack), 32'd1);
    chk("first_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("first_va", 32'(va), 32'h40000);
    chk("first_n_vrd", 32'(n_vrd), 32'd0);
    vid_req = 1'b0;
    @(negedge clk28);
    chk("vid_acc2_n_vrd", 32'(n_vrd), 32'd0);
    chk("vid_acc2_ack", 32'(vid_ack), 32'd0);
    vd_in = 8'h5A;
    @(negedge clk28);
    chk("second_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("second_dma_ack", 32'(dma_ack), 32'd0);
    chk("second_va", 32'(va), 32'h00100);
    chk("vid_rvalid", 32'(vid_rvalid), 32'd1);
    chk("vid_rdata", 32'(vid_rdata), 32'h5A);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk28);
    chk("cpu_acc2_rvalid", 32'(cpu_rvalid), 32'd0);
    vd_in = 8'h11;
    @(negedge clk28);
    chk("cpu1_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("cpu1_rdata", 32'(cpu_rdata), 32'h11);
    chk("vid_rvalid_pulse", 32'(vid_rvalid), 32'd0);
    chk("vid_rdata_hold", 32'(vid_rdata), 32'h5A);
    chk("idle_n_vrd", 32'(n_vrd), 32'd1);
    @(negedge clk28);
    chk("cpu1_rvalid_pulse", 32'(cpu_rvalid), 32'd0);

    // CPU read of 0x12345.
    cpu_addr = 19'h12345;
    cpu_wr   = 1'b0;
    cpu_req  = 1'b1;
    vd_in    = 8'hA5;
    @(negedge clk28);
    chk("rd_ack", 32'(cpu_ack), 32'd1);
    chk("rd_n_vrd1", 32'(n_vrd), 32'd0);
    chk("rd_va", 32'(va), 32'h12345);
    chk("rd_vd_oe", 32'(vd_oe), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk28);
    chk("rd_n_vrd2", 32'(n_vrd), 32'd0);
    chk("rd_ack_drop", 32'(cpu_ack), 32'd0);
    chk("rd_rvalid_early", 32'(cpu_rvalid), 32'd0);
    @(negedge clk28);
    chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
    chk("rd_n_vrd_end", 32'(n_vrd), 32'd1);

    // CPU write of 0x3C to 0x7FFFF.
    cpu_addr  = 19'h7FFFF;
    cpu_wr    = 1'b1;
    cpu_wdata = 8'h3C;
    cpu_req   = 1'b1;
    @(negedge clk28);
    chk("wr_ack", 32'(cpu_ack), 32'd1);
    chk("wr_oe1", 32'(vd_oe), 32'd1);
    chk("wr_n_vwr1", 32'(n_vwr), 32'd1);
    chk("wr_n_vrd1", 32'(n_vrd), 32'd1);
    chk("wr_vd_out", 32'(vd_out), 32'h3C);
    chk("wr_va", 32'(va), 32'h7FFFF);
    cpu_req   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = 8'h00;
    cpu_addr  = 19'h0;
    @(negedge clk28);
    chk("wr_oe2", 32'(vd_oe), 32'd1);
    chk("wr_n_vwr2", 32'(n_vwr), 32'd0);
    chk("wr_n_vrd2", 32'(n_vrd), 32'd1);
    chk("wr_vd_out2", 32'(vd_out), 32'h3C);
    @(negedge clk28);
    chk("wr_oe_end", 32'(vd_oe), 32'd0);
    chk("wr_n_vwr_end", 32'(n_vwr), 32'd1);
    chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
    @(negedge clk28);
    chk("wr_no_rvalid2", 32'(cpu_rvalid), 32'd0);

    // Video arrives during a CPU ACC1 while the CPU keeps requesting.
    cpu_addr = 19'h00ABC;
    cpu_req  = 1'b1;
    vd_in    = 8'h77;
    @(negedge clk28);
    chk("pre_cpu_ack", 32'(cpu_ack), 32'd1);
    vid_req  = 1'b1;
    vid_addr = 19'h1F00F;
    @(negedge clk28);
    chk("pre_acc2_vid_ack", 32'(vid_ack), 32'd0);
    chk("pre_acc2_cpu_ack", 32'(cpu_ack), 32'd0);
    @(negedge clk28);
    chk("pre_vid_ack", 32'(vid_ack), 32'd1);
    chk("pre_cpu_blocked", 32'(cpu_ack), 32'd0);
    chk("pre_vid_va", 32'(va), 32'h1F00F);
    chk("pre_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("pre_cpu_rdata", 32'(cpu_rdata), 32'h77);
    vid_req = 1'b0;
    vd_in   = 8'h66;
    @(negedge clk28);
    chk("pre_vid_acc2", 32'(vid_ack), 32'd0);
    @(negedge clk28);
    chk("post_cpu_ack", 32'(cpu_ack), 32'd1);
    chk("post_vid_rvalid", 32'(vid_rvalid), 32'd1);
    chk("post_vid_rdata", 32'(vid_rdata), 32'h66);
    cpu_req = 1'b0;
    @(negedge clk28);
    @(negedge clk28);
    chk("post_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("post_vid_rvalid_x", 32'(vid_rvalid), 32'd0);

    // Reset pulse during ACC2 of a write aborts it.
    cpu_addr  = 19'h00055;
    cpu_wr    = 1'b1;
    cpu_wdata = 8'h99;
    cpu_req   = 1'b1;
    @(negedge clk28);
    chk("abort_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    cpu_wr  = 1'b0;
    @(negedge clk28);
    chk("abort_pre_n_vwr", 32'(n_vwr), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_n_vwr", 32'(n_vwr), 32'd1);
    chk("abort_vd_oe", 32'(vd_oe), 32'd0);
    chk("abort_n_vrd", 32'(n_vrd), 32'd1);
    @(negedge clk28);
    rst_n = 1'b1;
    @(negedge clk28);
    chk("abort_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("abort_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("abort_idle_n_vwr", 32'(n_vwr), 32'd1);
    cpu_addr = 19'h00001;
    cpu_req  = 1'b1;
    @(negedge clk28);
    chk("abort_idle_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk28);

`ifdef SRAM_ARBITER_DMA_EN
    // CPU and DMA both held: 8 CPU grants, 1 DMA grant, repeat.
    begin
      int gcnt;
      gcnt = 0;
      cpu_addr = 19'h00010;
      dma_addr = 19'h00020;
      cpu_req  = 1'b1;
      dma_req  = 1'b1;
      for (int c = 0; c < 60 && gcnt < 19; c++) begin
        @(negedge clk28);
        if (cpu_ack || dma_ack) begin
          chk($sformatf("starve_dma_%0d", gcnt), 32'(dma_ack),
              32'((gcnt == 8 || gcnt == 17) ? 1 : 0));
          gcnt++;
        end
      end
      chk("starve_grants", 32'(gcnt), 32'd19);
      cpu_req = 1'b0;
      dma_req = 1'b0;
      repeat (3) @(negedge clk28);
    end
`else
    // DMA port is inert in this build.
    dma_req = 1'b1;
    repeat (4) begin
      @(negedge clk28);
      chk("nodma_ack", 32'(dma_ack), 32'd0);
      chk("nodma_n_vrd", 32'(n_vrd), 32'd1);
    end
    chk("nodma_rdata", 32'(dma_rdata), 32'd0);
    chk("nodma_rvalid", 32'(dma_rvalid), 32'd0);
    dma_req = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
